run_cmd_sequencer: RTL and testbench
====================================

// Module: run_cmd_sequencer
// PURPOSE
//   Upstream driver of the run/fault control FSM. Accepts a run command (length in cycles) over a
//   valid/ready handshake, then produces that FSM's start/done/fault inputs.
//   Fault sources: a filtered sensor over-limit, an external abort, and a start-acknowledge timeout.
//   Consumes the FSM's busy/error outputs to close the handshake loop.
// PARAMETERS
//   LEN_W      16   width of command run length (cycles)
//   DATA_W     12   width of sensor sample (unsigned)
//   LIMIT      3000 sensor over-limit threshold; sensor_val > LIMIT counts as exceed
//   FILT_N     4    consecutive exceed cycles required to raise fault (>=1)
//   ACK_TMO    8    max cycles waiting for fsm_busy after start before fault
//   FAULT_HOLD 16   minimum cycles fault_o is held asserted
// PORTS
//   clk         in   1       clock
//   rst_n       in   1       asynchronous active-low reset
//   cmd_valid   in   1       command present
//   cmd_ready   out  1       command accepted when valid&ready
//   cmd_len     in   LEN_W   run length; 0 treated as 1
//   abort       in   1       request abort of current run (level)
//   sensor_val  in   DATA_W  sampled sensor value, valid every cycle
//   fsm_busy    in   1       downstream FSM in RUN
//   fsm_error   in   1       downstream FSM in FAULT
//   start_o     out  1       to FSM in_start
//   done_o      out  1       to FSM in_done
//   fault_o     out  1       to FSM in_fault
//   seq_state   out  3       current sequencer state (debug)
//   fault_cause out  2       0 none, 1 sensor, 2 abort, 3 ack timeout; sticky until next accept
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low. All outputs registered.
//   Reset: state IDLE, cmd_ready=1, start_o=done_o=fault_o=0, fault_cause=0, counters 0.
//   States: IDLE(0) START(1) RUN(2) DONE(3) FAULT(4).
//   IDLE: cmd_ready=1. On cmd_valid: latch max(cmd_len,1), clear fault_cause, -> START. ready=0 elsewhere.
//   START: start_o=1; ack counter increments. fsm_busy=1 -> RUN (counter loads len).
//     ack counter reaches ACK_TMO without busy -> FAULT, cause 3.
//   RUN: start_o=1 (FSM ignores it in RUN). Counter decrements each cycle.
//     Counter==1 in a cycle -> next cycle done_o=1, state DONE.
//     Fault priority per cycle: abort > sensor filter > done. Abort or filter trip -> FAULT.
//   Sensor filter: consecutive-exceed count, saturating at FILT_N, cleared by any non-exceed cycle;
//     active only in RUN; trips when count reaches FILT_N. Cleared on entry to RUN.
//   DONE: done_o=1 for exactly one cycle, start_o=0 from DONE entry (lets FSM return to IDLE).
//     Wait fsm_busy=0 and fsm_error=0 -> IDLE.
//   FAULT: fault_o=1, start_o=0, done_o=0. Hold counter counts FAULT_HOLD cycles;
//     leave to IDLE only when hold expired AND abort=0. fault_o drops on IDLE entry.
//   fsm_error seen outside FAULT: ignore (debug only); fsm_busy drop during RUN: -> FAULT, cause 3.
//   Simultaneous abort and counter==1: abort wins (FAULT, not DONE).
//   cmd_valid held during non-IDLE: not accepted, no effect; command must stay valid until ready.
//   Reset mid-run: immediate return to reset values; no done/fault pulse produced.
//   Counter widths: run counter LEN_W, ack counter clog2(ACK_TMO+1), hold clog2(FAULT_HOLD+1).
// STRUCTURE
//   Package run_seq_pkg: seq_state_t enum (values above), fault_cause_t enum, default param consts.
//   Sub-module limit_filter (threshold compare + saturating consecutive counter, enable, clear, trip).
//   Top: one registered FSM plus run/ack/hold counters.
// TESTING
//   Nominal: cmd_len=5, busy returned 1 cycle after start -> done_o one pulse 5 cycles after RUN, back IDLE.
//   cmd_len=0 -> behaves as length 1; done_o on cycle after RUN entry.
//   Sensor 3001 for 3 cycles then 2999, later 4 cycles -> fault only after 4th consecutive, cause=1.
//   fsm_busy never asserted -> fault_o after 8 START cycles, cause=3, held >=16 cycles.
//   abort on same cycle counter==1 -> FAULT cause=2, no done_o; abort held 30 cycles -> exit at cycle 31.
//   rst_n low during RUN -> all outputs 0, cmd_ready=1 asynchronously; new command accepted after release.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the run/fault command sequencer.
package run_seq_pkg;

  localparam int LEN_W_DEF      = 16;
  localparam int DATA_W_DEF     = 12;
  localparam int LIMIT_DEF      = 3000;
  localparam int FILT_N_DEF     = 4;
  localparam int ACK_TMO_DEF    = 8;
  localparam int FAULT_HOLD_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_SENSOR  = 2'd1,
    CAUSE_ABORT   = 2'd2,
    CAUSE_ACK_TMO = 2'd3
  } fault_cause_t;

endpackage

// File: rtl/run_cmd_sequencer_limit_filter.sv
// Sensor over-limit filter: counts consecutive exceeding samples and flags a trip
// on the sample that makes the run of exceeds reach FILT_N.
module limit_filter #(
  parameter int DATA_W = 12,
  parameter int LIMIT  = 3000,
  parameter int FILT_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] sample,
  output logic              trip
);

  localparam int CNT_W = $clog2(FILT_N + 1);
  localparam logic [DATA_W-1:0] LIMIT_V = DATA_W'(LIMIT);
  localparam logic [CNT_W-1:0]  FILT_V  = CNT_W'(FILT_N);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             exceed_s;

  // Next count and trip decision; trip fires combinationally so the FSM reacts on the same sample.
  always_comb begin
    exceed_s   = (sample > LIMIT_V);
    cnt_next_s = cnt_r;
    trip       = 1'b0;
    if (clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (en) begin
      if (exceed_s) begin
        if (cnt_r < FILT_V) begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_next_s = cnt_r;
        end
        trip = (cnt_r >= (FILT_V - CNT_W'(1)));
      end else begin
        cnt_next_s = {CNT_W{1'b0}};
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Consecutive-exceed counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/run_cmd_sequencer.sv
// Accepts a run command and drives the downstream run/fault FSM's start/done/fault
// inputs, watching sensor over-limit, abort and start-acknowledge timeout.
module run_cmd_sequencer
  import run_seq_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LIMIT      = LIMIT_DEF,
  parameter int FILT_N     = FILT_N_DEF,
  parameter int ACK_TMO    = ACK_TMO_DEF,
  parameter int FAULT_HOLD = FAULT_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] sensor_val,
  input  logic              fsm_busy,
  input  logic              fsm_error,
  output logic              start_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [2:0]        seq_state,
  output logic [1:0]        fault_cause
);

  localparam int ACK_W  = $clog2(ACK_TMO + 1);
  localparam int HOLD_W = $clog2(FAULT_HOLD + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TMO - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLD - 1);

  seq_state_t        state_r, state_next_s;
  fault_cause_t      cause_r, cause_next_s;
  logic [LEN_W-1:0]  len_r, len_next_s;
  logic [LEN_W-1:0]  run_cnt_r, run_cnt_next_s;
  logic [ACK_W-1:0]  ack_cnt_r, ack_cnt_next_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_next_s;
  logic              filt_en_s, filt_clr_s, filt_trip_s;
  logic              cmd_ready_r, start_r, done_r, fault_r;

  limit_filter #(
    .DATA_W (DATA_W),
    .LIMIT  (LIMIT),
    .FILT_N (FILT_N)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (filt_en_s),
    .clr    (filt_clr_s),
    .sample (sensor_val),
    .trip   (filt_trip_s)
  );

  // Next-state, counter and fault-cause logic.
  always_comb begin
    state_next_s    = state_r;
    cause_next_s    = cause_r;
    len_next_s      = len_r;
    run_cnt_next_s  = run_cnt_r;
    ack_cnt_next_s  = ack_cnt_r;
    hold_cnt_next_s = hold_cnt_r;
    filt_en_s       = (state_r == ST_RUN);
    filt_clr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_next_s     = (cmd_len == {LEN_W{1'b0}}) ? LEN_W'(1) : cmd_len;
          cause_next_s   = CAUSE_NONE;
          ack_cnt_next_s = {ACK_W{1'b0}};
          state_next_s   = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (fsm_busy) begin
          run_cnt_next_s = len_r;
          filt_clr_s     = 1'b1;
          state_next_s   = ST_RUN;
        end else if (ack_cnt_r >= ACK_LAST) begin
          cause_next_s    = CAUSE_ACK_TMO;
          hold_cnt_next_s = {HOLD_W{1'b0}};
          state_next_s    = ST_FAULT;
        end else begin
          ack_cnt_next_s = ack_cnt_r + ACK_W'(1);
        end
      end
      ST_RUN: begin
        // Abort beats the sensor filter, which beats a lost busy, which beats completion.
        if (run_cnt_r != {LEN_W{1'b0}}) begin
          run_cnt_next_s = run_cnt_r - LEN_W'(1);
        end else begin
          run_cnt_next_s = run_cnt_r;
        end
        if (abort) begin
          cause_next_s    = CAUSE_ABORT;
          hold_cnt_next_s = {HOLD_W{1'b0}};
          state_next_s    = ST_FAULT;
        end else if (filt_trip_s) begin
          cause_next_s    = CAUSE_SENSOR;
          hold_cnt_next_s = {HOLD_W{1'b0}};
          state_next_s    = ST_FAULT;
        end else if (!fsm_busy) begin
          cause_next_s    = CAUSE_ACK_TMO;
          hold_cnt_next_s = {HOLD_W{1'b0}};
          state_next_s    = ST_FAULT;
        end else if (run_cnt_r == LEN_W'(1)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!fsm_busy && !fsm_error) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_FAULT: begin
        if (hold_cnt_r >= HOLD_LAST) begin
          if (!abort) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_FAULT;
          end
        end else begin
          hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cause_r     <= CAUSE_NONE;
      len_r       <= {LEN_W{1'b0}};
      run_cnt_r   <= {LEN_W{1'b0}};
      ack_cnt_r   <= {ACK_W{1'b0}};
      hold_cnt_r  <= {HOLD_W{1'b0}};
      cmd_ready_r <= 1'b1;
      start_r     <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cause_r     <= cause_next_s;
      len_r       <= len_next_s;
      run_cnt_r   <= run_cnt_next_s;
      ack_cnt_r   <= ack_cnt_next_s;
      hold_cnt_r  <= hold_cnt_next_s;
      cmd_ready_r <= (state_next_s == ST_IDLE);
      start_r     <= (state_next_s == ST_START) || (state_next_s == ST_RUN);
      done_r      <= (state_next_s == ST_DONE) && (state_r != ST_DONE);
      fault_r     <= (state_next_s == ST_FAULT);
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign start_o     = start_r;
  assign done_o      = done_r;
  assign fault_o     = fault_r;
  assign seq_state   = state_r;
  assign fault_cause = cause_r;

endmodule

// File: tb/tb_run_cmd_sequencer.sv
// Bench for run_cmd_sequencer: per-transaction stimulus plans, with expected phases
// derived from the sequencing rules by scanning each plan for its terminating event.
module tb_run_cmd_sequencer;

  localparam int N = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        abort;
  logic [11:0] sensor_val;
  logic        fsm_busy;
  logic        fsm_error;
  logic        start_o;
  logic        done_o;
  logic        fault_o;
  logic [2:0]  seq_state;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  run_cmd_sequencer #(
    .LEN_W(16), .DATA_W(12), .LIMIT(3000), .FILT_N(4), .ACK_TMO(8), .FAULT_HOLD(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .abort(abort), .sensor_val(sensor_val), .fsm_busy(fsm_busy),
    .fsm_error(fsm_error), .start_o(start_o), .done_o(done_o), .fault_o(fault_o),
    .seq_state(seq_state), .fault_cause(fault_cause)
  );

  int n_pass = 0, n_fail = 0, n_checks = 0;

  // Stimulus plan, indexed by clock edge counted from the accepting edge (index 0).
  bit          busy_a[N];
  bit          err_a[N];
  bit          abort_a[N];
  logic [11:0] sens_a[N];

  // Expected phase after each edge: 0 idle, 1 start, 2 run, 3 done, 4 fault.
  int ph[N];
  int done_at, fault_at, idle_at, cause_e, prev_cause;

  task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp_v);
    end
  endtask

  task automatic clear_plan();
    for (int c = 0; c < N; c++) begin
      busy_a[c] = 1'b0; err_a[c] = 1'b0; abort_a[c] = 1'b0; sens_a[c] = 12'd0;
    end
  endtask

  task automatic model(input int len_in);
    int lp, b, consec, e;
    lp = (len_in == 0) ? 1 : len_in;
    done_at = -1; fault_at = -1; cause_e = 0; b = -1;
    for (int c = 0; c < N; c++) ph[c] = 0;
    ph[0] = 1;
    for (int j = 1; j <= 8; j++) begin
      if (busy_a[j]) begin b = j; break; end
    end
    if (b < 0) begin
      for (int j = 1; j < 8; j++) ph[j] = 1;
      fault_at = 8; cause_e = 3;
    end else begin
      for (int j = 1; j < b; j++) ph[j] = 1;
      ph[b] = 2;
      consec = 0;
      for (int k = 1; k <= lp; k++) begin
        e = b + k;
        if (abort_a[e]) begin fault_at = e; cause_e = 2; break; end
        consec = (sens_a[e] > 12'd3000) ? consec + 1 : 0;
        if (consec >= 4) begin fault_at = e; cause_e = 1; break; end
        if (!busy_a[e]) begin fault_at = e; cause_e = 3; break; end
        if (k == lp) begin done_at = e; break; end
        ph[e] = 2;
      end
    end
    idle_at = N - 1;
    if (done_at >= 0) begin
      ph[done_at] = 3;
      for (int j = done_at + 1; j < N; j++) begin
        if (!busy_a[j] && !err_a[j]) begin idle_at = j; break; end
        ph[j] = 3;
      end
    end else begin
      ph[fault_at] = 4;
      for (int m = 1; fault_at + m < N; m++) begin
        if (m >= 16 && !abort_a[fault_at + m]) begin idle_at = fault_at + m; break; end
        ph[fault_at + m] = 4;
      end
    end
    ph[idle_at] = 0;
  endtask

  task automatic check_cycle(input int c);
    chk("seq_state", c, 16'(seq_state), 16'(ph[c]));
    chk("cmd_ready", c, 16'(cmd_ready), (ph[c] == 0) ? 16'd1 : 16'd0);
    chk("start_o", c, 16'(start_o), (ph[c] == 1 || ph[c] == 2) ? 16'd1 : 16'd0);
    chk("done_o", c, 16'(done_o), (c == done_at) ? 16'd1 : 16'd0);
    chk("fault_o", c, 16'(fault_o), (ph[c] == 4) ? 16'd1 : 16'd0);
    chk("fault_cause", c, 16'(fault_cause), (fault_at >= 0 && c >= fault_at) ? 16'(cause_e) : 16'd0);
  endtask

  task automatic drive(input int c);
    abort = abort_a[c]; sensor_val = sens_a[c]; fsm_busy = busy_a[c]; fsm_error = err_a[c];
  endtask

  task automatic run_plan(input logic [15:0] len);
    model(int'(len));
    chk("pre_ready", -1, 16'(cmd_ready), 16'd1);
    chk("pre_state", -1, 16'(seq_state), 16'd0);
    chk("pre_cause", -1, 16'(fault_cause), 16'(prev_cause));
    cmd_valid = 1'b1; cmd_len = len;
    drive(0);
    @(posedge clk); #1;
    check_cycle(0);
    for (int c = 1; c <= idle_at; c++) begin
      drive(c);
      @(posedge clk); #1;
      if (c >= 1) cmd_valid = 1'b0;
      check_cycle(c);
    end
    abort = 1'b0; fsm_busy = 1'b0; fsm_error = 1'b0; sensor_val = 12'd0;
    prev_cause = (fault_at >= 0) ? cause_e : 0;
  endtask

  initial begin
    int len_i, lp_g, bp, off, mode, as_i, al_i;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 16'd0; abort = 1'b0;
    sensor_val = 12'd0; fsm_busy = 1'b0; fsm_error = 1'b0; prev_cause = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", -1, 16'(cmd_ready), 16'd1);
    chk("rst_state", -1, 16'(seq_state), 16'd0);
    chk("rst_outs", -1, 16'({start_o, done_o, fault_o}), 16'd0);
    chk("rst_cause", -1, 16'(fault_cause), 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // Nominal: length 5, busy one cycle after start.
    clear_plan();
    for (int c = 1; c <= 7; c++) busy_a[c] = 1'b1;
    run_plan(16'd5);

    // Zero length behaves as one.
    clear_plan();
    for (int c = 1; c <= 3; c++) busy_a[c] = 1'b1;
    run_plan(16'd0);

    // Sensor: three exceeds, a dip, then four exceeds trip the filter.
    clear_plan();
    for (int c = 1; c <= 25; c++) busy_a[c] = 1'b1;
    for (int c = 2; c <= 4; c++) sens_a[c] = 12'd3001;
    sens_a[5] = 12'd2999;
    sens_a[6] = 12'd3000;
    for (int c = 8; c <= 11; c++) sens_a[c] = 12'd3001;
    run_plan(16'd20);

    // No busy ever: acknowledge timeout.
    clear_plan();
    run_plan(16'd3);

    // Abort on the last run cycle, held 30 cycles.
    clear_plan();
    for (int c = 1; c <= 7; c++) busy_a[c] = 1'b1;
    for (int c = 6; c <= 35; c++) abort_a[c] = 1'b1;
    run_plan(16'd5);

    // Asynchronous reset in the middle of a run.
    cmd_valid = 1'b1; cmd_len = 16'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0; fsm_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_state", -1, 16'(seq_state), 16'd2);
    chk("mid_start", -1, 16'(start_o), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", -1, 16'(cmd_ready), 16'd1);
    chk("arst_state", -1, 16'(seq_state), 16'd0);
    chk("arst_outs", -1, 16'({start_o, done_o, fault_o}), 16'd0);
    chk("arst_cause", -1, 16'(fault_cause), 16'd0);
    @(negedge clk); rst_n = 1'b1; fsm_busy = 1'b0; prev_cause = 0;
    clear_plan();
    for (int c = 1; c <= 7; c++) busy_a[c] = 1'b1;
    run_plan(16'd5);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      clear_plan();
      len_i = $urandom_range(0, 12);
      lp_g  = (len_i == 0) ? 1 : len_i;
      bp    = $urandom_range(1, 10);
      off   = bp + lp_g + $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0) off = bp + $urandom_range(1, lp_g);
      mode  = $urandom_range(0, 2);
      for (int c = 1; c < N; c++) begin
        busy_a[c] = (c >= bp && c < off);
        if (c < 100) err_a[c] = ($urandom_range(0, 7) == 0);
        if (mode == 0)      sens_a[c] = 12'($urandom_range(0, 3000));
        else if (mode == 1) sens_a[c] = 12'($urandom_range(2996, 3004));
        else                sens_a[c] = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 2) == 0) begin
        as_i = $urandom_range(1, 30);
        al_i = $urandom_range(1, 30);
        for (int c = as_i; c < as_i + al_i; c++) abort_a[c] = 1'b1;
      end
      run_plan(16'(len_i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
